// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and bit-timing constants for the USB receive path
// Purpose: timer state encoding plus the bit-timing and bit-stuffing constants
//          used by usb_rx_timer and its counters.
// Ports:   none (package).
package usb_rx_pkg;

    localparam int CLKS_PER_BIT  = 8;
    localparam int SAMPLE_PHASE  = 3;
    localparam int MAX_ONES      = 6;
    localparam int BITS_PER_BYTE = 8;

    localparam int PHASE_W  = $clog2(CLKS_PER_BIT);
    localparam int BITCNT_W = $clog2(BITS_PER_BYTE);
    localparam int ONES_W   = $clog2(MAX_ONES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } timer_state_e;

endpackage

// File: rtl/usb_rx_timer_if.sv
// rtl/usb_rx_timer_if.sv - control/status bundle between RX control unit and bit timer
// Purpose: groups the timer's control inputs and pulse outputs.
// Signals: enable_timer, d_edge, d_orig, eop      (control unit -> timer)
//          shift_enable, byte_complete, stuff_error (timer -> control unit)
// Modports: master = control unit side, slave = timer side.
interface usb_rx_timer_if;

    logic enable_timer;
    logic d_edge;
    logic d_orig;
    logic eop;
    logic shift_enable;
    logic byte_complete;
    logic stuff_error;

    modport master (
        output enable_timer,
        output d_edge,
        output d_orig,
        output eop,
        input  shift_enable,
        input  byte_complete,
        input  stuff_error
    );

    modport slave (
        input  enable_timer,
        input  d_edge,
        input  d_orig,
        input  eop,
        output shift_enable,
        output byte_complete,
        output stuff_error
    );

endinterface

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - up counter with parameterised width and rollover value
// Purpose: counts 0..ROLLOVER_VAL then wraps to 0; clear has priority over count.
// Ports:   clk, n_rst      - clock, synchronous active-low reset
//          clear_i         - force count to 0 on the next edge
//          count_enable_i  - advance the count on the next edge
//          count_o         - current count
//          rollover_flag_o - count currently equals ROLLOVER_VAL (next advance wraps)
module flex_counter #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] ROLLOVER_VAL = '1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic             count_enable_i,
    output logic [WIDTH-1:0] count_o,
    output logic             rollover_flag_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_enable_i) begin
            count_d = (count_q == ROLLOVER_VAL) ? '0 : count_q + 1'b1;
        end
    end

    assign count_o         = count_q;
    assign rollover_flag_o = (count_q == ROLLOVER_VAL);

endmodule

// File: rtl/usb_rx_timer.sv
// rtl/usb_rx_timer.sv - USB receive bit timer with bit-stuff removal and byte framing
// Purpose: recovers the mid-bit sample point from an 8x clock, drops stuffed zeros,
//          flags stuffing violations and marks every 8th delivered bit.
// Ports:   clk   - system clock, 8 clocks per bit time
//          n_rst - synchronous active-low reset
//          bus   - usb_rx_timer_if.slave: enable_timer, d_edge, d_orig, eop in;
//                  registered one-cycle pulses shift_enable, byte_complete, stuff_error out
module usb_rx_timer
    import usb_rx_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    usb_rx_timer_if.slave bus
);

    timer_state_e state_q;
    timer_state_e state_d;

    logic [PHASE_W-1:0]  phase;
    logic [BITCNT_W-1:0] bit_cnt;
    logic                bit_roll;
    logic                phase_wrap_unused;

    logic [ONES_W-1:0]   ones_q;
    logic [ONES_W-1:0]   ones_d;
    logic                shift_enable_q;
    logic                shift_enable_d;
    logic                stuff_error_q;
    logic                stuff_error_d;
    logic                byte_pend_q;
    logic                byte_pend_d;
    logic                byte_complete_q;

    logic sample_pt;
    logic abort_run;
    logic ones_full;
    logic take_sample;
    logic stuff_viol;
    logic do_shift;

    // Sampling is suppressed on an edge cycle because the phase is being
    // realigned; eop or a dropped enable abort the packet before any sample.
    assign sample_pt   = (state_q == ST_RUN) && !bus.d_edge &&
                         (phase == PHASE_W'(SAMPLE_PHASE));
    assign abort_run   = bus.eop || !bus.enable_timer;
    assign ones_full   = (ones_q == ONES_W'(MAX_ONES));
    assign take_sample = sample_pt && !abort_run;
    assign stuff_viol  = take_sample && bus.d_orig && ones_full;
    // After six ones the next bit is either the stuffed zero or a violation,
    // so it is never delivered.
    assign do_shift    = take_sample && !ones_full;

    flex_counter #(
        .WIDTH        (PHASE_W),
        .ROLLOVER_VAL (PHASE_W'(CLKS_PER_BIT - 1))
    ) u_phase_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         ((state_d == ST_IDLE) ||
                          (state_q == ST_RUN && state_d == ST_RUN && bus.d_edge)),
        .count_enable_i  ((state_q == ST_RUN) && (state_d == ST_RUN)),
        .count_o         (phase),
        // Bit timing keys off the sample phase, not the wrap point.
        .rollover_flag_o (phase_wrap_unused)
    );

    flex_counter #(
        .WIDTH        (BITCNT_W),
        .ROLLOVER_VAL (BITCNT_W'(BITS_PER_BYTE - 1))
    ) u_bit_cnt (
        .clk             (clk),
        .n_rst           (n_rst),
        .clear_i         (state_d == ST_IDLE),
        .count_enable_i  (do_shift),
        .count_o         (bit_cnt),
        .rollover_flag_o (bit_roll)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.enable_timer) state_d = ST_RUN;
            ST_RUN: begin
                if (abort_run) begin
                    state_d = ST_IDLE;
                end else if (stuff_viol) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR:  if (!bus.enable_timer) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        shift_enable_d = do_shift;
        stuff_error_d  = stuff_viol;
        // Last bit of a byte: byte_complete follows its shift_enable by one cycle.
        byte_pend_d    = do_shift && bit_roll;
        ones_d         = ones_q;
        if (state_d == ST_IDLE) begin
            ones_d = '0;
        end else if (take_sample) begin
            if (!bus.d_orig) begin
                ones_d = '0;
            end else if (!ones_full) begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    // byte_pend -> byte_complete runs regardless of state so a byte whose last
    // bit was already shifted still completes across a disable or eop.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ones_q          <= '0;
            shift_enable_q  <= 1'b0;
            stuff_error_q   <= 1'b0;
            byte_pend_q     <= 1'b0;
            byte_complete_q <= 1'b0;
        end else begin
            ones_q          <= ones_d;
            shift_enable_q  <= shift_enable_d;
            stuff_error_q   <= stuff_error_d;
            byte_pend_q     <= byte_pend_d;
            byte_complete_q <= byte_pend_q;
        end
    end

    assign bus.shift_enable  = shift_enable_q;
    assign bus.byte_complete = byte_complete_q;
    assign bus.stuff_error   = stuff_error_q;

endmodule

// File: tb/tb_usb_rx_timer.sv
// tb/tb_usb_rx_timer.sv - scoreboard bench for usb_rx_timer
module tb_usb_rx_timer;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_rx_timer_if bus();

    usb_rx_timer dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        bit [2:0] val;   // {shift_enable, byte_complete, stuff_error}
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_se  = 0;
    int   n_bc  = 0;
    int   n_er  = 0;

    // Reference model: where the receiver is in the packet, in plain terms.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;
    int m_mode  = M_IDLE;
    int m_ph    = 0;     // clocks since the last bit boundary, mod 8
    int m_ones  = 0;     // consecutive delivered ones
    int m_nbits = 0;     // bits delivered in the current byte
    bit m_pend  = 1'b0;  // byte finished, completion pulse due next clock

    task automatic model_go_idle();
        m_mode  = M_IDLE;
        m_ph    = 0;
        m_ones  = 0;
        m_nbits = 0;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit de,
                              input bit dor, input bit eop);
        bit   se = 1'b0;
        bit   bc = 1'b0;
        bit   er = 1'b0;
        exp_t e;
        if (!rst) begin
            model_go_idle();
            m_pend = 1'b0;
        end else begin
            bc     = m_pend;
            m_pend = 1'b0;
            case (m_mode)
                M_IDLE: if (en) m_mode = M_RUN;
                M_RUN: begin
                    if (eop || !en) begin
                        model_go_idle();
                    end else if (m_ph == 3 && !de) begin
                        if (dor && m_ones == 6) begin
                            er     = 1'b1;
                            m_mode = M_ERR;
                        end else begin
                            if (!dor && m_ones == 6) begin
                                m_ones = 0;          // stuffed zero removed
                            end else begin
                                m_ones  = dor ? m_ones + 1 : 0;
                                se      = 1'b1;
                                m_nbits = m_nbits + 1;
                                if (m_nbits == 8) begin
                                    m_nbits = 0;
                                    m_pend  = 1'b1;
                                end
                            end
                            m_ph = 4;
                        end
                    end else begin
                        m_ph = de ? 0 : (m_ph + 1) % 8;
                    end
                end
                default: if (!en) model_go_idle();
            endcase
        end
        if ({se, bc, er} != 3'b000) begin
            e.cyc = cyc + 1;
            e.val = {se, bc, er};
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input bit rst, input bit en, input bit de,
                         input bit dor, input bit eop);
        @(posedge clk);
        #2;
        n_rst            = rst;
        bus.enable_timer = en;
        bus.d_edge       = de;
        bus.d_orig       = dor;
        bus.eop          = eop;
        model_step(rst, en, de, dor, eop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses or a pulse is due.
    bit [2:0] act;
    bit [2:0] expv;
    initial begin
        forever begin
            @(negedge clk);
            act = {bus.shift_enable, bus.byte_complete, bus.stuff_error};
            n_se += int'(act[2]);
            n_bc += int'(act[1]);
            n_er += int'(act[0]);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL stale_expect cyc=%0d actual=none required=%b", exp_q[0].cyc, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            expv = 3'b000;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                expv = exp_q[0].val;
                void'(exp_q.pop_front());
            end
            if (expv != 3'b000 || act != 3'b000) begin
                total++;
                if (act !== expv) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act, expv);
                end
            end
        end
    end

    int s_se, s_bc, s_er;

    task automatic mark();
        s_se = n_se;
        s_bc = n_bc;
        s_er = n_er;
    endtask

    task automatic check_counts(input string name, input int e_se, input int e_bc, input int e_er);
        idle(3);
        @(negedge clk);
        #1;
        total++;
        if ((n_se - s_se) != e_se || (n_bc - s_bc) != e_bc || (n_er - s_er) != e_er) begin
            bad++;
            $display("FAIL %s actual se=%0d bc=%0d er=%0d required se=%0d bc=%0d er=%0d",
                     name, n_se - s_se, n_bc - s_bc, n_er - s_er, e_se, e_bc, e_er);
        end
    endtask

    bit [8:0] pat;
    bit       en_r;
    int       guard;

    initial begin
        n_rst            = 1'b0;
        bus.enable_timer = 1'b0;
        bus.d_edge       = 1'b0;
        bus.d_orig       = 1'b0;
        bus.eop          = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        total++;
        if ({bus.shift_enable, bus.byte_complete, bus.stuff_error} !== 3'b000) begin
            bad++;
            $display("FAIL reset_outputs actual=%b required=000",
                     {bus.shift_enable, bus.byte_complete, bus.stuff_error});
        end
        idle(2);

        // Free-running zeros, no edges
        mark();
        for (int i = 0; i < 65; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_counts("free_run_64", 8, 1, 0);

        // Sync byte 0x80, LSB first, edge at every zero bit
        mark();
        pat = 9'h080;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < 8; c++)
                drive(1'b1, 1'b1, (c == 0) && !pat[b], pat[b], 1'b0);
        check_counts("sync_0x80", 8, 1, 0);

        // Seven ones: stuffing violation
        mark();
        pat = 9'b0_0111_1111;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 64; i++) drive(1'b1, 1'b1, 1'b0, pat[(i - 1) / 8], 1'b0);
        check_counts("stuff_error", 6, 0, 1);

        // Six ones, stuffed zero, two zeros
        mark();
        pat = 9'b0_0011_1111;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 72; i++) drive(1'b1, 1'b1, 1'b0, pat[(i - 1) / 8], 1'b0);
        check_counts("stuffed_zero", 8, 1, 0);

        // eop on the sample cycle of bit 6
        mark();
        guard = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        while (!(m_nbits == 5 && m_ph == 3) && guard < 100) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check_counts("eop_partial", 5, 0, 0);

        // Reset after four bits, then a fresh full byte
        mark();
        guard = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        while (m_nbits != 4 && guard < 100) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_counts("reset_mid_byte", 12, 1, 0);

        // Random traffic against the model
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (en_r) en_r = ($urandom_range(0, 149) != 0);
            else      en_r = ($urandom_range(0, 4) == 0);
            drive($urandom_range(0, 599) != 0, en_r,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 299) == 0);
        end

        idle(3);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
